cnn_conv_sequencer: RTL and testbench
=====================================

Name: cnn_conv_sequencer

Overview:
- Sequences one 3x3 valid convolution over an 8-bit image in user memory for the cnn_top datapath.
- Loads the run configuration on start, walks every output window, issues 9 tap reads per window and accumulates them with a signed kernel.
- Scales and clamps each result, writes it back, then pulses done.
- Sits between the cnn_top register file (base addresses, start) and the shared user memory port. Uses a req/gnt handshake so an arbiter can share that port.

Parameters:
- DATA_WIDTH, 8, pixel, weight and memory data width.
- ADDR_WIDTH, 32, memory address width.
- DIM_WIDTH, 8, width of the image width/height inputs.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; ignored while busy_o=1.
- in_base_i  in  ADDR_WIDTH  input image base address.
- out_base_i  in  ADDR_WIDTH  output image base address.
- img_w_i  in  DIM_WIDTH  image width in pixels.
- img_h_i  in  DIM_WIDTH  image height in pixels.
- kernel_i  in  9*DATA_WIDTH  signed weights; tap k = ky*3+kx sits at bits [k*DW +: DW].
- shift_i  in  4  arithmetic right shift applied to the accumulator.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at end of run.
- err_o  out  1  one-cycle pulse with done_o when the image size is illegal.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_rd_en_o  out  1  read request.
- mem_wr_en_o  out  1  write request.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_gnt_i  in  1  grant for the current request.
- mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a granted read.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high. Reset drives all outputs to 0, FSM to IDLE and clears counters and accumulator. Reset mid-run aborts immediately: no done_o, no further memory requests.
- Configuration capture: start_i in IDLE samples all configuration inputs into registers. Later input changes have no effect on the run.
- Size check: img_w<3 or img_h<3 gives ERR for one cycle (done_o=err_o=1), then IDLE. No memory access occurs.
- FSM states:
  - IDLE -> RD on a legal start; tap=0, acc=0.
  - RD: mem_rd_en_o=1, addr = in_base + (row+ky)*img_w + (col+kx).
    - On gnt, tap increments; the returned pixel (unsigned, zero-extended) times its signed weight is added to acc in the following cycle.
    - Without gnt, the request is held with addr stable.
    - After the tap-8 grant -> DRAIN.
  - DRAIN: one cycle; the last product is added.
  - WR: mem_wr_en_o=1, addr = out_base + row*(img_w-2) + col, wdata = clamp(acc >>> shift_i). Held until gnt.
  - On the WR grant: col increments; at col = img_w-3, col wraps to 0 and row increments; after the last window -> DONE, otherwise -> RD with acc cleared.
  - DONE: done_o=1 for one cycle, busy_o=0 next cycle, -> IDLE.
- busy_o=1 in every state except IDLE.
- Handshake: rd_en and wr_en are never both high. With gnt tied high, each window takes exactly 11 cycles, and done_o asserts 11*N_out+1 cycles after the start cycle.
- Arithmetic: acc is signed, 2*DATA_WIDTH+4 bits wide; it cannot overflow for 9 taps. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Clamp: signed saturation to [-2^(DW-1), 2^(DW-1)-1]; the two's-complement byte is written.

Optional Feature:
- Macro CNN_SEQ_RELU_EN.
- When defined: clamp is ReLU plus unsigned saturation to [0, 2^DW-1].
- When undefined: signed saturation as described above.

Decomposition:
- Package cnn_seq_pkg holds:
  - state enum (IDLE, RD, DRAIN, WR, DONE, ERR);
  - KTAPS=9;
  - ACC_W function of DATA_WIDTH;
  - clamp function.
- One sub-module, cnn_mac_unit: clear, accumulate, shift and clamp. The sequencer owns the FSM, counters and address generation.

Test Plan:
1. 3x3 image 10..90, kernel all 1, shift 1, gnt=1:
   - single write to out_base;
   - data 225 with RELU_EN, 127 without;
   - done_o 12 cycles after start.
2. 4x4 ramp 0..15, kernel centre=1 and others 0, shift 0: writes 5, 6, 9, 10 to out_base+0..3 in order; done at 45 cycles.
3. 3x3 image 10..90, kernel all -1, shift 0: writes 0 with RELU_EN, 0x80 without.
4. gnt low for 5 cycles during tap 4 and for 3 cycles during WR:
   - addr and rd_en/wr_en held stable;
   - result same as scenario 1;
   - done delayed by exactly 8 cycles.
5. img_w=2, start: done_o=err_o=1 one cycle later; no rd_en or wr_en ever asserted.
6. Reset during the second window of scenario 2, then a restart: all outputs 0 after reset; the restarted run completes correctly. A start during busy is ignored.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the 3x3 conv sequencer.
// CNN_SEQ_RELU_EN: clamp() becomes ReLU + unsigned saturation.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DRAIN,
    WR,
    DONE,
    ERR
  } state_t;

  localparam int KTAPS = 9;

  function automatic int acc_w(input int dw);
    return 2 * dw + 4;
  endfunction

  function automatic logic [31:0] clamp(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    logic signed [63:0] r;
`ifdef CNN_SEQ_RELU_EN
    lo = 64'sd0;
    hi = (64'sd1 <<< dw) - 64'sd1;
`else
    lo = -(64'sd1 <<< (dw - 1));
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
`endif
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    else r = v;
    return 32'(r);
  endfunction

endpackage

// File: rtl/cnn_mac_unit.sv
// Signed MAC: clr/acc of pixel*weight, then shift + clamp.
// Ports: clk_i, rst_i, clr_i, acc_en_i, pix_i, wgt_i, shift_i -> res_o.
module cnn_mac_unit
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  acc_en_i,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic [DATA_WIDTH-1:0] wgt_i,
  input  logic [3:0]            shift_i,
  output logic [DATA_WIDTH-1:0] res_o
);
  localparam int AW = acc_w(DATA_WIDTH);
  localparam int PW = 2 * DATA_WIDTH + 1;

  logic signed [AW-1:0] r_acc;
  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_wx;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_x;
  logic signed [AW-1:0] w_shr;
  logic signed [63:0]   w_sx;

  // pixel is unsigned, weight signed
  assign w_px = {{(PW-DATA_WIDTH){1'b0}}, pix_i};
  assign w_wx = {{(PW-DATA_WIDTH){wgt_i[DATA_WIDTH-1]}}, wgt_i};
  assign w_prod = w_px * w_wx;
  assign w_prod_x = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_shr = r_acc >>> shift_i;
  assign w_sx = {{(64-AW){w_shr[AW-1]}}, w_shr};
  assign res_o = DATA_WIDTH'(clamp(w_sx, DATA_WIDTH));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) r_acc <= '0;
    else if (acc_en_i) r_acc <= r_acc + w_prod_x;
  end

endmodule

// File: rtl/cnn_conv_sequencer.sv
// 3x3 valid-conv sequencer: config capture, tap reads, MAC, write-back.
// Ports: start/config in, busy/done/err out, req/gnt memory port.
module cnn_conv_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   in_base_i,
  input  logic [ADDR_WIDTH-1:0]   out_base_i,
  input  logic [DIM_WIDTH-1:0]    img_w_i,
  input  logic [DIM_WIDTH-1:0]    img_h_i,
  input  logic [9*DATA_WIDTH-1:0] kernel_i,
  input  logic [3:0]              shift_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_rd_en_o,
  output logic                    mem_wr_en_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int KW = KTAPS * DATA_WIDTH;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_in_base;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [DIM_WIDTH-1:0]  r_w;
  logic [DIM_WIDTH-1:0]  r_h;
  logic [DIM_WIDTH-1:0]  r_row;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [KW-1:0]         r_kernel;
  logic [3:0]            r_shift;
  logic [3:0]            r_tap;
  logic [3:0]            r_ptap;
  logic [1:0]            r_kx;
  logic [1:0]            r_ky;
  logic                  r_pend;

  logic                  w_start;
  logic                  w_legal;
  logic                  w_rd_gnt;
  logic                  w_wr_gnt;
  logic                  w_last_tap;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [DIM_WIDTH-1:0]  w_ry;
  logic [DIM_WIDTH-1:0]  w_cx;
  logic [DIM_WIDTH-1:0]  w_ow;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wgt;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_start = (r_state == IDLE) && start_i;
  assign w_legal = (img_w_i >= DIM_WIDTH'(3))
                && (img_h_i >= DIM_WIDTH'(3));
  assign w_rd_gnt = (r_state == RD) && mem_gnt_i;
  assign w_wr_gnt = (r_state == WR) && mem_gnt_i;
  assign w_last_tap = r_tap == 4'(KTAPS - 1);
  assign w_last_col = r_col == r_w - DIM_WIDTH'(3);
  assign w_last_row = r_row == r_h - DIM_WIDTH'(3);

  assign w_ry = r_row + DIM_WIDTH'(r_ky);
  assign w_cx = r_col + DIM_WIDTH'(r_kx);
  assign w_ow = r_w - DIM_WIDTH'(2);
  assign w_rd_addr = r_in_base
    + ADDR_WIDTH'(w_ry) * ADDR_WIDTH'(r_w)
    + ADDR_WIDTH'(w_cx);
  assign w_wr_addr = r_out_base
    + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(w_ow)
    + ADDR_WIDTH'(r_col);

  // weight of the read granted last cycle
  assign w_wgt = r_kernel[int'(r_ptap) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start_i) w_next = w_legal ? RD : ERR;
      RD:    if (mem_gnt_i && w_last_tap) w_next = DRAIN;
      DRAIN: w_next = WR;
      WR:    if (mem_gnt_i)
               w_next = (w_last_col && w_last_row) ? DONE : RD;
      DONE:  w_next = IDLE;
      ERR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      IDLE: busy_o = 1'b0;
      RD: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = w_rd_addr;
      end
      WR: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = w_wr_addr;
        mem_wdata_o = w_res;
      end
      DONE: done_o = 1'b1;
      ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_base  <= '0;
      r_out_base <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_kernel   <= '0;
      r_shift    <= '0;
      r_tap      <= '0;
      r_ptap     <= '0;
      r_kx       <= '0;
      r_ky       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_pend <= w_rd_gnt;
      if (w_start) begin
        r_in_base  <= in_base_i;
        r_out_base <= out_base_i;
        r_w        <= img_w_i;
        r_h        <= img_h_i;
        r_kernel   <= kernel_i;
        r_shift    <= shift_i;
        r_tap      <= '0;
        r_kx       <= '0;
        r_ky       <= '0;
        r_row      <= '0;
        r_col      <= '0;
      end
      if (w_rd_gnt) begin
        r_ptap <= r_tap;
        r_tap  <= w_last_tap ? 4'd0 : r_tap + 4'd1;
        if (r_kx == 2'd2) begin
          r_kx <= 2'd0;
          r_ky <= (r_ky == 2'd2) ? 2'd0 : r_ky + 2'd1;
        end else begin
          r_kx <= r_kx + 2'd1;
        end
      end
      if (w_wr_gnt) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + DIM_WIDTH'(1);
        end else begin
          r_col <= r_col + DIM_WIDTH'(1);
        end
      end
    end
  end

  cnn_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_start || w_wr_gnt),
    .acc_en_i (r_pend),
    .pix_i    (mem_rdata_i),
    .wgt_i    (w_wgt),
    .shift_i  (r_shift),
    .res_o    (w_res)
  );

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Self-checking bench for cnn_conv_sequencer.
// Memory/arbiter model plus a loop-based convolution reference.
module tb_cnn_conv_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [31:0] in_base = 0;
  logic [31:0] out_base = 0;
  logic [7:0]  img_w = 0;
  logic [7:0]  img_h = 0;
  logic [71:0] kernel = 0;
  logic [3:0]  shift = 0;
  logic        busy, done, err, rd_en, wr_en;
  logic        gnt = 0;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata = 0;

  always #5 clk = ~clk;

  cnn_conv_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_base_i(in_base), .out_base_i(out_base),
    .img_w_i(img_w), .img_h_i(img_h),
    .kernel_i(kernel), .shift_i(shift),
    .busy_o(busy), .done_o(done), .err_o(err),
    .mem_addr_o(addr), .mem_rd_en_o(rd_en),
    .mem_wr_en_o(wr_en), .mem_wdata_o(wdata),
    .mem_gnt_i(gnt), .mem_rdata_i(rdata)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [4096];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gmode = 0;
  int stall_rd_n = 0;
  int stall_wr_n = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, req_cnt = 0;
  int both_viol = 0, hold_viol = 0;
  int rd_win = 0, rd_stalled = 0, wr_stalled = 0;
  bit pend = 0, pstall = 0;
  logic [31:0] paddr = 0, pa = 0;
  logic prd = 0, pwr = 0;
  logic [7:0] pwd = 0;
  logic [39:0] got_q [$];

  always @(negedge clk) begin
    rdata = pend ? mem[paddr[11:0]] : 8'h00;
    pend = 0;
    if (rst) begin
      rd_win = 0; rd_stalled = 0; wr_stalled = 0; pstall = 0;
    end
    if (pstall && (rd_en !== prd || wr_en !== pwr || addr !== pa
        || (pwr && wdata !== pwd)))
      hold_viol++;
    if (rd_en && wr_en) both_viol++;
    if (rd_en || wr_en) req_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (gmode == 1) gnt = ($urandom_range(0, 3) != 0);
    else if (gmode == 2 && rd_en && rd_win == 4
             && rd_stalled < stall_rd_n) begin
      gnt = 0; rd_stalled++;
    end else if (gmode == 2 && wr_en && wr_stalled < stall_wr_n) begin
      gnt = 0; wr_stalled++;
    end else gnt = 1;
    if (rd_en && gnt) begin pend = 1; paddr = addr; rd_win++; end
    if (wr_en && gnt) begin
      got_q.push_back({addr, wdata});
      rd_win = 0; rd_stalled = 0; wr_stalled = 0;
    end
    pstall = (rd_en || wr_en) && !gnt;
    prd = rd_en; pwr = wr_en; pa = addr; pwd = wdata;
  end

  logic [31:0] cfg_in, cfg_out;
  int cfg_w, cfg_h, cfg_sh;
  logic [71:0] cfg_k;
  logic [39:0] exp_q [$];

  function automatic int clampv(input int v);
`ifdef CNN_SEQ_RELU_EN
    return v < 0 ? 0 : (v > 255 ? 255 : v);
`else
    return v < -128 ? -128 : (v > 127 ? 127 : v);
`endif
  endfunction

  task automatic build_ref();
    int acc, v;
    logic [31:0] a;
    logic [7:0] wb;
    exp_q.delete();
    for (int r = 0; r + 3 <= cfg_h; r++)
      for (int c = 0; c + 3 <= cfg_w; c++) begin
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          a = cfg_in + 32'((r + k / 3) * cfg_w + c + k % 3);
          wb = cfg_k[k*8 +: 8];
          acc += int'(mem[a[11:0]]) * int'($signed(wb));
        end
        v = clampv(acc >>> cfg_sh);
        exp_q.push_back({cfg_out + 32'(r * (cfg_w - 2) + c), 8'(v)});
      end
  endtask

  task automatic run_cfg(input int poke, output int lat, output bit ok);
    int d0, s;
    d0 = done_cnt;
    @(posedge clk); #1;
    in_base = cfg_in; out_base = cfg_out;
    img_w = 8'(cfg_w); img_h = 8'(cfg_h);
    kernel = cfg_k; shift = 4'(cfg_sh);
    start = 1; s = cyc;
    @(posedge clk); #1;
    start = 0;
    in_base = $urandom(); out_base = $urandom();
    img_w = 8'($urandom()); img_h = 8'($urandom());
    kernel = 72'({$urandom(), $urandom(), $urandom()});
    shift = 4'($urandom());
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      start = (i == poke);
    end
    start = 0;
    ok = (done_cnt != d0);
    lat = done_cyc - s;
  endtask

  task automatic fill_seq(input logic [31:0] base, input int n,
                          input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      mem[a[11:0]] = 8'(i * mul + add);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, rd_en, wr_en, addr, wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, done, err, rd_en, wr_en, addr, wdata});
    end
    start = 0; rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_sum3x3();
    int lat, g0, e0, b0, want;
    bit ok;
    fill_seq(32'h100, 9, 10, 10);
    cfg_in = 32'h100; cfg_out = 32'h800; cfg_w = 3; cfg_h = 3;
    cfg_k = {9{8'h01}}; cfg_sh = 1;
    build_ref();
    g0 = got_q.size(); e0 = err_cnt; b0 = both_viol;
    run_cfg(-1, lat, ok);
`ifdef CNN_SEQ_RELU_EN
    want = 225;
`else
    want = 127;
`endif
    checks++;
    if (!ok) begin errors++; $display("FAIL s1_timeout no done"); end
    checks++;
    if (lat !== 12) begin
      errors++; $display("FAIL s1_latency got %0d want 12", lat);
    end
    checks++;
    if (got_q.size() - g0 !== 1) begin
      errors++;
      $display("FAIL s1_nwrites got %0d want 1", got_q.size() - g0);
    end else begin
      checks++;
      if (got_q[g0] !== {32'h800, 8'(want)}) begin
        errors++;
        $display("FAIL s1_write got %h want %h", got_q[g0],
                 {32'h800, 8'(want)});
      end
      checks++;
      if (got_q[g0] !== exp_q[0]) begin
        errors++;
        $display("FAIL s1_ref got %h want %h", got_q[g0], exp_q[0]);
      end
    end
    checks++;
    if (err_cnt - e0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL s1_err_busy got err=%0d busy=%b want 0 0",
               err_cnt - e0, busy);
    end
    checks++;
    if (both_viol !== b0) begin
      errors++; $display("FAIL s1_rd_wr_both got %0d want %0d",
                         both_viol, b0);
    end
  endtask

  task automatic test_ramp4x4(input int poke, input string nm);
    int lat, g0;
    int w2 [4] = '{5, 6, 9, 10};
    bit ok;
    fill_seq(32'h100, 16, 1, 0);
    cfg_in = 32'h100; cfg_out = 32'h800; cfg_w = 4; cfg_h = 4;
    cfg_k = '0; cfg_k[39:32] = 8'd1; cfg_sh = 0;
    build_ref();
    g0 = got_q.size();
    run_cfg(poke, lat, ok);
    checks++;
    if (!ok || lat !== 45) begin
      errors++;
      $display("FAIL %s_latency got %0d ok=%0d want 45", nm, lat, ok);
    end
    checks++;
    if (got_q.size() - g0 !== 4) begin
      errors++;
      $display("FAIL %s_nwrites got %0d want 4", nm, got_q.size() - g0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[g0+i] !== {32'h800 + 32'(i), 8'(w2[i])}
            || got_q[g0+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_write%0d got %h want %h", nm, i,
                   got_q[g0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_negkernel();
    int lat, g0;
    bit ok;
    logic [7:0] want;
    fill_seq(32'h100, 9, 10, 10);
    cfg_in = 32'h100; cfg_out = 32'h800; cfg_w = 3; cfg_h = 3;
    cfg_k = {9{8'hFF}}; cfg_sh = 0;
`ifdef CNN_SEQ_RELU_EN
    want = 8'h00;
`else
    want = 8'h80;
`endif
    g0 = got_q.size();
    run_cfg(-1, lat, ok);
    checks++;
    if (!ok || got_q.size() - g0 !== 1) begin
      errors++;
      $display("FAIL s3_run got ok=%0d n=%0d want 1 1", ok,
               got_q.size() - g0);
    end else if (got_q[g0][7:0] !== want) begin
      errors++;
      $display("FAIL s3_data got %h want %h", got_q[g0][7:0], want);
    end
  endtask

  task automatic test_stall();
    int lat, g0, h0;
    bit ok;
    fill_seq(32'h100, 9, 10, 10);
    cfg_in = 32'h100; cfg_out = 32'h800; cfg_w = 3; cfg_h = 3;
    cfg_k = {9{8'h01}}; cfg_sh = 1;
    build_ref();
    gmode = 2; stall_rd_n = 5; stall_wr_n = 3;
    g0 = got_q.size(); h0 = hold_viol;
    run_cfg(-1, lat, ok);
    gmode = 0;
    checks++;
    if (!ok || lat !== 20) begin
      errors++; $display("FAIL s4_latency got %0d want 20", lat);
    end
    checks++;
    if (hold_viol !== h0) begin
      errors++;
      $display("FAIL s4_hold got %0d want 0", hold_viol - h0);
    end
    checks++;
    if (got_q.size() - g0 !== 1 || got_q[g0] !== exp_q[0]) begin
      errors++;
      $display("FAIL s4_write got %h want %h", got_q[g0], exp_q[0]);
    end
  endtask

  task automatic test_illegal(input int w, input int h);
    int lat, g0, e0, r0;
    bit ok;
    cfg_in = 32'h100; cfg_out = 32'h800; cfg_w = w; cfg_h = h;
    cfg_k = {9{8'h01}}; cfg_sh = 0;
    g0 = got_q.size(); e0 = err_cnt; r0 = req_cnt;
    run_cfg(-1, lat, ok);
    checks++;
    if (!ok || lat !== 1 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL s5_err w=%0d h=%0d got lat=%0d err=%0d want 1 1",
               w, h, lat, err_cnt - e0);
    end
    checks++;
    if (req_cnt !== r0 || got_q.size() !== g0) begin
      errors++;
      $display("FAIL s5_noreq got %0d want 0", req_cnt - r0);
    end
  endtask

  task automatic test_reset_midrun();
    int d0, g0, r0;
    fill_seq(32'h100, 16, 1, 0);
    d0 = done_cnt; g0 = got_q.size();
    @(posedge clk); #1;
    in_base = 32'h100; out_base = 32'h800; img_w = 4; img_h = 4;
    kernel = '0; kernel[39:32] = 8'd1; shift = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, rd_en, wr_en, addr, wdata} !== '0) begin
      errors++;
      $display("FAIL s6_reset_outputs got %h want 0",
               {busy, done, err, rd_en, wr_en, addr, wdata});
    end
    checks++;
    if (got_q.size() - g0 !== 1) begin
      errors++;
      $display("FAIL s6_prewrites got %0d want 1", got_q.size() - g0);
    end
    rst = 0; r0 = req_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (req_cnt !== r0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL s6_abort got req=%0d done=%0d want 0 0",
               req_cnt - r0, done_cnt - d0);
    end
    test_ramp4x4(20, "s6");
  endtask

  task automatic test_random();
    int lat, g0, h0, b0, e0;
    bit ok;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
    gmode = 1;
    for (int n = 0; n < 6; n++) begin
      cfg_in = (n % 2 == 1) ? 32'hFFFF_FFF0 : $urandom_range(0, 2000);
      cfg_out = $urandom();
      cfg_w = $urandom_range(3, 6); cfg_h = $urandom_range(3, 5);
      cfg_k = 72'({$urandom(), $urandom(), $urandom()});
      cfg_sh = $urandom_range(0, 9);
      build_ref();
      g0 = got_q.size(); h0 = hold_viol; b0 = both_viol;
      e0 = err_cnt;
      run_cfg(-1, lat, ok);
      checks++;
      if (!ok || err_cnt !== e0) begin
        errors++;
        $display("FAIL rnd%0d_done got ok=%0d err=%0d want 1 0", n, ok,
                 err_cnt - e0);
      end
      checks++;
      if (hold_viol !== h0 || both_viol !== b0) begin
        errors++;
        $display("FAIL rnd%0d_handshake got hold=%0d both=%0d want 0 0",
                 n, hold_viol - h0, both_viol - b0);
      end
      checks++;
      if (got_q.size() - g0 !== exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_nwrites got %0d want %0d", n,
                 got_q.size() - g0, exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[g0+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd%0d_write%0d got %h want %h", n, i,
                     got_q[g0+i], exp_q[i]);
          end
        end
      end
    end
    gmode = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_sum3x3();
    test_ramp4x4(-1, "s2");
    test_negkernel();
    test_stall();
    test_illegal(2, 5);
    test_illegal(5, 2);
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
